matrix_conv2d: RTL and testbench

//  Valid-mode 2-D convolution (cross-correlation) of a signed 16-bit fixed-point feature map with a KxK kernel.

---
 rtl/matrix_conv2d.sv | 260 ++++++++++++++++++++++++++
 tb/tb_matrix_conv2d.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_conv2d.sv
// ---------------------------------------------------------------------------
// matrix_conv2d
//   Valid-mode 2-D cross-correlation of a signed Q7.8 feature map with a KxK
//   kernel. Input map and kernel are fetched from synchronous RAMs with a
//   1-clock read latency. Each output is written saturated to a dest RAM in
//   row-major order. Every output takes K*K+2 clocks: K*K tap issues, one
//   drain cycle for the last returning tap, and one write cycle.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   start / done             level start (sampled in IDLE); done high in DONE
//   src1_*                   input map base/size, read address, read data
//   src2_*                   kernel base/size, read address, read data
//   bias                     signed Q7.8 offset added to every output
//   dest_*                   output base, write address/data/strobe
// ---------------------------------------------------------------------------
module matrix_conv2d #(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [13:0] src1_start_address,
    input  logic [9:0]  src1_row_size,
    input  logic [9:0]  src1_col_size,
    output logic [13:0] src1_address,
    input  logic [15:0] src1_readdata,
    input  logic [13:0] src2_start_address,
    input  logic [5:0]  src2_row_size,
    input  logic [5:0]  src2_col_size,
    output logic [13:0] src2_address,
    input  logic [15:0] src2_readdata,
    input  logic [15:0] bias,
    input  logic [13:0] dest_start_address,
    output logic [13:0] dest_address,
    output logic [15:0] dest_writedata,
    output logic        dest_write_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Configuration captured when a run starts; inputs are ignored afterwards.
    logic [13:0] s1_base_q, s1_base_d;
    logic [13:0] s2_base_q, s2_base_d;
    logic [13:0] d_base_q,  d_base_d;
    logic [9:0]  col_q,     col_d;      // input columns C
    logic [5:0]  k_q,       k_d;        // kernel size K
    logic [9:0]  ro_q,      ro_d;       // output rows
    logic [9:0]  co_q,      co_d;       // output cols
    logic [15:0] bias_q,    bias_d;

    // Output position and kernel tap counters.
    logic [9:0]  r_q, r_d;
    logic [9:0]  c_q, c_d;
    logic [5:0]  i_q, i_d;
    logic [5:0]  j_q, j_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    // High in the cycle where read data for a tap issued last cycle arrives.
    logic acc_en_q, acc_en_d;

    // Accumulator start value: bias aligned to the product's 2*FRAC_BITS scale.
    function automatic logic signed [ACC_W-1:0] preload(input logic [15:0] b);
        return {{(ACC_W-16-FRAC_BITS){b[15]}}, b, {FRAC_BITS{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] shifted;

    assign prod     = $signed(src1_readdata) * $signed(src2_readdata);
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign shifted  = acc_q >>> FRAC_BITS;

    // Saturate: the value fits in 16 bits only if all bits from 15 upward agree.
    always_comb begin
        if ((&shifted[ACC_W-1:15]) || !(|shifted[ACC_W-1:15])) begin
            dest_writedata = shifted[15:0];
        end else if (shifted[ACC_W-1]) begin
            dest_writedata = 16'h8000;
        end else begin
            dest_writedata = 16'h7FFF;
        end
    end

    // Address generation. Offsets are computed modulo the 14-bit address space.
    logic [10:0] row_idx;
    logic [10:0] col_idx;
    logic [13:0] row_off;
    logic [13:0] k_off;
    logic [13:0] dest_off;

    assign row_idx  = {1'b0, r_q} + {5'b0, i_q};
    assign col_idx  = {1'b0, c_q} + {5'b0, j_q};
    assign row_off  = 14'(row_idx) * 14'(col_q);
    assign k_off    = 14'(i_q) * 14'(k_q);
    assign dest_off = 14'(r_q) * 14'(co_q);

    assign src1_address  = s1_base_q + row_off + {3'b0, col_idx};
    assign src2_address  = s2_base_q + k_off + {8'b0, j_q};
    assign dest_address  = d_base_q + dest_off + {4'b0, c_q};
    assign dest_write_en = (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            s1_base_q <= '0;
            s2_base_q <= '0;
            d_base_q  <= '0;
            col_q     <= '0;
            k_q       <= '0;
            ro_q      <= '0;
            co_q      <= '0;
            bias_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            acc_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_base_q <= s1_base_d;
            s2_base_q <= s2_base_d;
            d_base_q  <= d_base_d;
            col_q     <= col_d;
            k_q       <= k_d;
            ro_q      <= ro_d;
            co_q      <= co_d;
            bias_q    <= bias_d;
            r_q       <= r_d;
            c_q       <= c_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            acc_en_q  <= acc_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic cfg_bad;
    assign cfg_bad = (src2_row_size == 6'd0)
                  || (src2_col_size != src2_row_size)
                  || ({4'b0, src2_row_size} > src1_row_size)
                  || ({4'b0, src2_row_size} > src1_col_size);

    always_comb begin
        state_d   = state_q;
        s1_base_d = s1_base_q;
        s2_base_d = s2_base_q;
        d_base_d  = d_base_q;
        col_d     = col_q;
        k_d       = k_q;
        ro_d      = ro_q;
        co_d      = co_q;
        bias_d    = bias_q;
        r_d       = r_q;
        c_d       = c_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_en_d  = 1'b0;
        acc_d     = acc_q;

        // Read data always belongs to the tap issued one cycle earlier.
        if (acc_en_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s1_base_d = src1_start_address;
                    s2_base_d = src2_start_address;
                    d_base_d  = dest_start_address;
                    col_d     = src1_col_size;
                    k_d       = src2_row_size;
                    ro_d      = src1_row_size - {4'b0, src2_row_size} + 10'd1;
                    co_d      = src1_col_size - {4'b0, src2_row_size} + 10'd1;
                    bias_d    = bias;
                    r_d       = '0;
                    c_d       = '0;
                    i_d       = '0;
                    j_d       = '0;
                    if (cfg_bad) begin
                        state_d = S_DONE;
                    end else begin
                        acc_d   = preload(bias);
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                acc_en_d = 1'b1;
                if (j_q == k_q - 6'd1) begin
                    j_d = '0;
                    if (i_q == k_q - 6'd1) begin
                        i_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + 6'd1;
                    end
                end else begin
                    j_d = j_q + 6'd1;
                end
            end

            S_DRAIN: begin
                state_d = S_WRITE;
            end

            S_WRITE: begin
                if (c_q == co_q - 10'd1) begin
                    c_d = '0;
                    if (r_q == ro_q - 10'd1) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + 10'd1;
                        acc_d   = preload(bias_q);
                        state_d = S_ISSUE;
                    end
                end else begin
                    c_d     = c_q + 10'd1;
                    acc_d   = preload(bias_q);
                    state_d = S_ISSUE;
                end
            end

            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_conv2d.sv
module tb_matrix_conv2d;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic [13:0] src1_start_address = '0;
    logic [9:0]  src1_row_size = '0;
    logic [9:0]  src1_col_size = '0;
    logic [13:0] src1_address;
    logic [15:0] src1_readdata = '0;
    logic [13:0] src2_start_address = '0;
    logic [5:0]  src2_row_size = '0;
    logic [5:0]  src2_col_size = '0;
    logic [13:0] src2_address;
    logic [15:0] src2_readdata = '0;
    logic [15:0] bias = '0;
    logic [13:0] dest_start_address = '0;
    logic [13:0] dest_address;
    logic [15:0] dest_writedata;
    logic        dest_write_en;

    matrix_conv2d dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .src1_start_address (src1_start_address),
        .src1_row_size      (src1_row_size),
        .src1_col_size      (src1_col_size),
        .src1_address       (src1_address),
        .src1_readdata      (src1_readdata),
        .src2_start_address (src2_start_address),
        .src2_row_size      (src2_row_size),
        .src2_col_size      (src2_col_size),
        .src2_address       (src2_address),
        .src2_readdata      (src2_readdata),
        .bias               (bias),
        .dest_start_address (dest_start_address),
        .dest_address       (dest_address),
        .dest_writedata     (dest_writedata),
        .dest_write_en      (dest_write_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models with 1-clock read latency
    logic [15:0] in1_mem [0:16383];
    logic [15:0] k_mem   [0:16383];
    logic [15:0] dst_mem [0:16383];

    always @(posedge clk) begin
        src1_readdata <= in1_mem[src1_address];
        src2_readdata <= k_mem[src2_address];
        if (dest_write_en) dst_mem[dest_address] <= dest_writedata;
    end

    // Scoreboard
    logic [13:0] exp_addr_q [$];
    logic [15:0] exp_data_q [$];
    int          wr_cyc_q   [$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (!reset && dest_write_en) begin
            wr_cyc_q.push_back(cyc);
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", dest_address, dest_writedata);
            end else begin
                logic [13:0] ea;
                logic [15:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (dest_address !== ea || dest_writedata !== ed) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h expected addr=%h data=%h", dest_address, dest_writedata, ea, ed);
                end else begin
                    $display("write addr=%h data=%h ok", dest_address, dest_writedata);
                end
            end
        end
    end

    task automatic configure(input int r, input int c, input int k, input int kc,
                             input logic [15:0] b, input logic [13:0] s1b,
                             input logic [13:0] s2b, input logic [13:0] db);
        @(negedge clk);
        src1_row_size      = 10'(r);
        src1_col_size      = 10'(c);
        src2_row_size      = 6'(k);
        src2_col_size      = 6'(kc);
        bias               = b;
        src1_start_address = s1b;
        src2_start_address = s2b;
        dest_start_address = db;
    endtask

    // Reference model: straightforward loops over the bench's own memory images.
    task automatic push_expected();
        int r, c, k, ro, co;
        r = int'(src1_row_size); c = int'(src1_col_size); k = int'(src2_row_size);
        ro = r - k + 1; co = c - k + 1;
        for (int orow = 0; orow < ro; orow++) begin
            for (int ocol = 0; ocol < co; ocol++) begin
                longint acc, v;
                logic [15:0] d;
                acc = longint'($signed(bias)) * 256;
                for (int i = 0; i < k; i++) begin
                    for (int j = 0; j < k; j++) begin
                        acc += longint'($signed(in1_mem[14'(int'(src1_start_address) + (orow + i) * c + ocol + j)]))
                             * longint'($signed(k_mem[14'(int'(src2_start_address) + i * k + j)]));
                    end
                end
                v = acc >>> 8;
                if (v > 32767) d = 16'h7FFF;
                else if (v < -32768) d = 16'h8000;
                else d = v[15:0];
                exp_addr_q.push_back(14'(int'(dest_start_address) + orow * co + ocol));
                exp_data_q.push_back(d);
            end
        end
    endtask

    task automatic run_until_done(input int bound, output bit ok, output int start_cyc);
        wr_cyc_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fill_const(input logic [13:0] base, input int n, input logic [15:0] v, input bit kern);
        for (int x = 0; x < n; x++) begin
            if (kern) k_mem[14'(int'(base) + x)] = v;
            else in1_mem[14'(int'(base) + x)] = v;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (dest_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", dest_write_en); end
        checks++; if (src1_address !== 14'd0) begin errors++; $display("FAIL reset_src1_addr got=%h want=0", src1_address); end
        checks++; if (src2_address !== 14'd0) begin errors++; $display("FAIL reset_src2_addr got=%h want=0", src2_address); end
        checks++; if (dest_address !== 14'd0) begin errors++; $display("FAIL reset_dest_addr got=%h want=0", dest_address); end
        checks++; if (dest_writedata !== 16'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", dest_writedata); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_basic();
        bit ok; int sc;
        fill_const(14'h0040, 16, 16'h0100, 1'b0);
        fill_const(14'h0010, 9, 16'h0100, 1'b1);
        for (int x = 0; x < 4; x++) dst_mem[x] = 16'h0000;
        configure(4, 4, 3, 3, 16'h0000, 14'h0040, 14'h0010, 14'h0000);
        push_expected();
        run_until_done(200, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done got=timeout want=done"); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d left want=0", exp_addr_q.size()); end
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (dst_mem[x] !== 16'h0900) begin errors++; $display("FAIL basic_dst%0d got=%h want=0900", x, dst_mem[x]); end
        end
        checks++;
        if (wr_cyc_q.size() != 4) begin
            errors++; $display("FAIL basic_wcount got=%0d want=4", wr_cyc_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[0] - sc != 10) begin errors++; $display("FAIL basic_latency got=%0d want=10", wr_cyc_q[0] - sc); end
            for (int x = 1; x < 4; x++) begin
                checks++;
                if (wr_cyc_q[x] - wr_cyc_q[x-1] != 11) begin
                    errors++; $display("FAIL basic_spacing got=%0d want=11", wr_cyc_q[x] - wr_cyc_q[x-1]);
                end
            end
        end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_negative();
        bit ok; int sc;
        fill_const(14'h0040, 16, 16'h0100, 1'b0);
        fill_const(14'h0010, 9, 16'hFF00, 1'b1);
        for (int x = 0; x < 4; x++) dst_mem[14'h0200 + x] = 16'h0000;
        configure(4, 4, 3, 3, 16'h0000, 14'h0040, 14'h0010, 14'h0200);
        push_expected();
        run_until_done(200, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL neg_done got=timeout want=done"); end
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (dst_mem[14'h0200 + x] !== 16'hF700) begin errors++; $display("FAIL neg_dst%0d got=%h want=F700", x, dst_mem[14'h0200 + x]); end
        end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_saturation();
        bit ok; int sc;
        fill_const(14'h0100, 9, 16'h7F00, 1'b0);
        fill_const(14'h0020, 9, 16'h7F00, 1'b1);
        dst_mem[14'h0300] = 16'h0000;
        configure(3, 3, 3, 3, 16'h0000, 14'h0100, 14'h0020, 14'h0300);
        push_expected();
        run_until_done(100, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL satp_done got=timeout want=done"); end
        checks++; if (dst_mem[14'h0300] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h want=7FFF", dst_mem[14'h0300]); end
        fill_const(14'h0020, 9, 16'h8100, 1'b1);
        configure(3, 3, 3, 3, 16'h0000, 14'h0100, 14'h0020, 14'h0300);
        push_expected();
        run_until_done(100, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL satn_done got=timeout want=done"); end
        checks++; if (dst_mem[14'h0300] !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h want=8000", dst_mem[14'h0300]); end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_k1();
        bit ok; int sc;
        // 2x3 map, scale 1.5, bias -0.5
        for (int x = 0; x < 6; x++) in1_mem[14'h0500 + x] = 16'(x * 300 - 700);
        k_mem[14'h0030] = 16'h0180;
        configure(2, 3, 1, 1, 16'hFF80, 14'h0500, 14'h0030, 14'h0400);
        push_expected();
        run_until_done(100, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL k1_done got=timeout want=done"); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL k1_missing got=%0d want=0", exp_addr_q.size()); end
        checks++;
        if (wr_cyc_q.size() != 6) begin
            errors++; $display("FAIL k1_wcount got=%0d want=6", wr_cyc_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[0] - sc != 2) begin errors++; $display("FAIL k1_latency got=%0d want=2", wr_cyc_q[0] - sc); end
            for (int x = 1; x < 6; x++) begin
                checks++;
                if (wr_cyc_q[x] - wr_cyc_q[x-1] != 3) begin
                    errors++; $display("FAIL k1_spacing got=%0d want=3", wr_cyc_q[x] - wr_cyc_q[x-1]);
                end
            end
        end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_random();
        bit ok; int sc;
        for (int x = 0; x < 42; x++) in1_mem[14'h0600 + x] = 16'($urandom_range(0, 65535));
        for (int x = 0; x < 9; x++) k_mem[14'h0040 + x] = 16'($urandom_range(0, 1023) - 512);
        configure(6, 7, 3, 3, 16'($urandom_range(0, 65535)), 14'h0600, 14'h0040, 14'h0700);
        push_expected();
        run_until_done(500, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL rand_done got=timeout want=done"); end
        checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL rand_missing got=%0d want=0", exp_addr_q.size()); end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic load_ramp();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                in1_mem[14'h1000 + r * 28 + c] = 16'((r * 28 + c) << 8);
        for (int x = 0; x < 9; x++) k_mem[14'h0080 + x] = (x == 4) ? 16'h0100 : 16'h0000;
    endtask

    task automatic test_ramp();
        bit ok; int sc;
        load_ramp();
        configure(28, 28, 3, 3, 16'h0080, 14'h1000, 14'h0080, 14'h2000);
        push_expected();
        run_until_done(8000, ok, sc);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_done got=timeout want=done"); end
        checks++; if (wr_cyc_q.size() != 676) begin errors++; $display("FAIL ramp_wcount got=%0d want=676", wr_cyc_q.size()); end
        checks++;
        if (dst_mem[14'h2000 + 5 * 26 + 7] !== 16'(((6 * 28 + 8) << 8) + 16'h0080)) begin
            errors++; $display("FAIL ramp_sample got=%h want=%h", dst_mem[14'h2000 + 5 * 26 + 7], 16'(((6 * 28 + 8) << 8) + 16'h0080));
        end
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_invalid();
        bit ok; int sc;
        int kr [3] = '{5, 0, 3};
        int kc [3] = '{5, 0, 2};
        for (int t = 0; t < 3; t++) begin
            configure(4, 4, kr[t], kc[t], 16'h0000, 14'h0040, 14'h0010, 14'h0000);
            run_until_done(2, ok, sc);
            checks++; if (!ok) begin errors++; $display("FAIL invalid%0d_done got=late want=within2", t); end
            checks++; if (wr_cyc_q.size() != 0) begin errors++; $display("FAIL invalid%0d_writes got=%0d want=0", t, wr_cyc_q.size()); end
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        bit hit;
        load_ramp();
        configure(28, 28, 3, 3, 16'h0080, 14'h1000, 14'h0080, 14'h2000);
        push_expected();
        @(negedge clk);
        start = 1'b1;
        seen = 0; hit = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #2;
            if (dest_write_en) seen++;
            if (seen == 100) begin hit = 1'b1; break; end
        end
        reset = 1'b1;
        #1;
        checks++; if (!hit) begin errors++; $display("FAIL midrun_reach100 got=%0d want=100", seen); end
        checks++; if (dest_write_en !== 1'b0) begin errors++; $display("FAIL midrun_we got=%b want=0", dest_write_en); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_done got=%b want=0", done); end
        checks++; if (dest_address !== 14'd0) begin errors++; $display("FAIL midrun_daddr got=%h want=0", dest_address); end
        checks++; if (dest_writedata !== 16'd0) begin errors++; $display("FAIL midrun_wdata got=%h want=0", dest_writedata); end
        checks++; if (src1_address !== 14'd0) begin errors++; $display("FAIL midrun_s1addr got=%h want=0", src1_address); end
        exp_addr_q.delete(); exp_data_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_basic();
    endtask

    initial begin
        for (int x = 0; x < 16384; x++) begin
            in1_mem[x] = '0; k_mem[x] = '0; dst_mem[x] = '0;
        end
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_k1();
        test_random();
        test_ramp();
        test_invalid();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
